// File: rtl/ex_div_stall_unit.sv
// rtl/ex_div_stall_unit.sv - multi-cycle EX-stage integer divider with pipeline stall request
//
// Restoring divider that raises stall_req_o while a DIV/DIVU occupies EX.
// Optional macro: DIV_EARLY_OUT_EN -- when |dividend| < |divisor| the
// result is produced straight from IDLE without iterating.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_i      divide requested by the instruction held in EX
//   signed_i     1 = DIV (signed), 0 = DIVU
//   annul_i      flush; abandon the current divide
//   dividend_i   dividend
//   divisor_i    divisor
//   result_o     {remainder, quotient}
//   ready_o      result_o valid
//   stall_req_o  EX stall request to the pipeline controller
module ex_div_stall_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   dividend_i,
  input  logic [WIDTH-1:0]   divisor_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_req_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;     // holds the dividend, shifted out as quotient bits shift in
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   dividend_mag, divisor_mag;
  logic [WIDTH:0]     trial_shift, trial_diff;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   final_rem, final_quo;

  // Datapath for one restoring step. The partial remainder is always below
  // the divisor, so the shifted value fits in WIDTH+1 bits and bit WIDTH of
  // the difference is the borrow of the trial subtraction.
  always_comb begin
    dividend_mag = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    divisor_mag  = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
    trial_shift  = {rem_q, quo_q[WIDTH-1]};
    trial_diff   = trial_shift - {1'b0, dvsr_q};
    step_quo     = {quo_q[WIDTH-2:0], ~trial_diff[WIDTH]};
    step_rem     = trial_diff[WIDTH] ? trial_shift[WIDTH-1:0] : trial_diff[WIDTH-1:0];
    final_quo    = neg_quo_q ? -step_quo : step_quo;
    final_rem    = neg_rem_q ? -step_rem : step_rem;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (annul_i) begin
      // Flush wins over everything, including a simultaneous start.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              state_d = BYZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (dividend_mag < divisor_mag) begin
              // Quotient is zero and the remainder is the dividend itself.
              state_d  = DONE;
              result_d = {dividend_i, {WIDTH{1'b0}}};
`endif
            end else begin
              state_d   = RUN;
              cnt_d     = '0;
              rem_d     = '0;
              quo_d     = dividend_mag;
              dvsr_d    = divisor_mag;
              neg_quo_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
              neg_rem_d = signed_i & dividend_i[WIDTH-1];
            end
          end
        end
        BYZERO: begin
          result_d = '0;
          state_d  = DONE;
        end
        RUN: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = {final_rem, final_quo};
          end
        end
        DONE: begin
          if (!start_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = (state_q == DONE);
  // Dropping the request in DONE lets the pipeline advance on that cycle.
  assign stall_req_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: doc/ex_div_stall_unit.md
Name: ex_div_stall_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage; the requesting end of the pipeline stall protocol.
- Drives stall_req_o, the EX stall request into the pipeline controller (EX request -> stall = 6'b001111), for as long as a DIV/DIVU is in progress.
- The held ID/EX register keeps start_i and operands stable until the result is ready and the request drops.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- start_i  input  1  divide requested by the instruction held in EX.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU.
- annul_i  input  1  flush; abandon the current divide.
- dividend_i  input  WIDTH  dividend.
- divisor_i  input  WIDTH  divisor.
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result_o valid.
- stall_req_o  output  1  EX stall request to the controller; 1 = Stop.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; result_o=0; ready_o=0; stall_req_o=0.
- States: IDLE, BYZERO, RUN, DONE.
- IDLE:
  - start_i=1, annul_i=0, divisor_i!=0 -> latch |dividend|, |divisor| and sign flags (magnitudes only when signed_i=1), counter=0, go to RUN.
  - start_i=1, annul_i=0, divisor_i=0 -> go to BYZERO.
  - Otherwise stay in IDLE.
- BYZERO: result_o={0,0}; go to DONE.
- RUN:
  - One restoring-division step per cycle: shift the partial remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit; counter++.
  - After step WIDTH (counter==WIDTH-1 this cycle), go to DONE.
- DONE entry (registered):
  - Quotient is negated if signed_i and the operand signs differ.
  - Remainder takes the dividend's sign.
  - ready_o=1.
- DONE exit:
  - Hold result_o and ready_o while start_i=1.
  - start_i=0 -> IDLE, ready_o=0; result_o holds its last value.
- Latency: start_i first sampled high in IDLE at cycle N -> RUN N+1..N+WIDTH -> DONE/ready_o=1 at N+WIDTH+1 (N+33 for WIDTH=32). Divide by zero: ready_o at N+2.
- stall_req_o:
  - Combinational: start_i & ~ready_o & ~annul_i.
  - Asserted from cycle N through the last RUN cycle; 0 in DONE, so the pipeline advances on the DONE cycle.
- annul_i=1 in any state:
  - Next state IDLE; ready_o=0; stall_req_o=0 immediately.
  - Wins over a simultaneous start_i.
- Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0 (wraps, no trap).
- Back-to-back divides: a new divide needs start_i low for at least one cycle (IDLE re-entry) before it is accepted.
- Operand changes during RUN are ignored; only the values latched in IDLE are used.
- Reset mid-RUN: immediate return to reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if divisor!=0 and |dividend| < |divisor| (unsigned compare of magnitudes), go straight to DONE.
  - Result: quotient=0, remainder=dividend_i, ready_o at N+1.
  - stall_req_o is high for cycle N only.
- Undefined: every non-zero-divisor divide takes the full WIDTH iterations.

Test Plan:
- DIVU 100/7, start_i held -> stall_req_o high cycles N..N+32; ready_o at N+33; result_o={0x2,0xE}; stall_req_o=0 at N+33.
- DIV 0xFFFFFFF9(-7)/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU of the same operands -> quotient 0x7FFFFFFC, remainder 1.
- Divisor 0, any dividend -> BYZERO; ready_o at N+2; result_o=0; stall_req_o high N..N+1.
- Annul at N+10 during RUN -> stall_req_o=0 the same cycle, IDLE next cycle, ready_o stays 0. A new start at N+12 completes correctly at N+12+33.
- DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. Then start_i low one cycle and a fresh DIVU 9/3 -> {0,3}.
- DIVU 3/10:
  - With DIV_EARLY_OUT_EN: ready_o at N+1, result_o={3,0}.
  - Without: ready_o at N+33, same result.
